// File: rtl/matrix_pkg.sv
// Shared constants and types for the LED matrix frame buffer and its scan driver.
// Pixel addresses are {row, col} so one row of the panel occupies COLS consecutive words.
package matrix_pkg;

  localparam int COLS   = 64;
  localparam int ROWS   = 32;
  localparam int PIX_W  = 3;

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int PAIR_W = ROW_W - 1;
  localparam int ADDR_W = COL_W + ROW_W;
  localparam int DEPTH  = COLS * ROWS;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fb_state_e;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COL_W-1:0] x,
                                                 input logic [ROW_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/matrix_fb_bank.sv
// One frame bank: a synchronous write port and two registered read ports that
// fetch the upper- and lower-half pixels of a column in the same cycle.
module matrix_fb_bank
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rgb_t              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_up,
  input  logic [ADDR_W-1:0] raddr_lo,
  output rgb_t              rdata_up,
  output rgb_t              rdata_lo
);

  rgb_t mem [DEPTH];
  rgb_t up_q;
  rgb_t lo_q;

  // No reset on the array or read registers so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      up_q <= mem[raddr_up];
      lo_q <= mem[raddr_lo];
    end
  end

  assign rdata_up = up_q;
  assign rdata_lo = lo_q;

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 64x32 RGB frame store: producer fills the back bank, scan driver
// reads the front bank, and the banks swap only on a scan frame boundary.
module matrix_frame_buffer
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [COL_W-1:0]  wr_x,
  input  logic [ROW_W-1:0]  wr_y,
  input  logic [PIX_W-1:0]  wr_rgb,
  input  logic              wr_frame_done,
  input  logic              rd_en,
  input  logic [COL_W-1:0]  rd_col,
  input  logic [PAIR_W-1:0] rd_row,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_rgb0,
  output logic [PIX_W-1:0]  rd_rgb1,
  input  logic              frame_start,
  output logic              active_bank,
  output logic              swap_pending
);

  fb_state_e state_q, state_d;
  logic      active_bank_q, active_bank_d;
  logic      swap_pending_q, swap_pending_d;
  logic      wr_ready_q, wr_ready_d;

  logic      rd_valid_q, rd_valid_d;
  logic      rd_sel_q, rd_sel_d;
  logic      rd_seen_q, rd_seen_d;

  logic              wr_fire;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr_up;
  logic [ADDR_W-1:0] rd_addr_lo;
  rgb_t              bank_up [2];
  rgb_t              bank_lo [2];

  always_comb begin
    state_d        = state_q;
    active_bank_d  = active_bank_q;
    swap_pending_d = swap_pending_q;
    wr_ready_d     = wr_ready_q;
    case (state_q)
      FILL: begin
        // frame_start alone never swaps here; the frame must be marked done first.
        if (wr_frame_done) begin
          state_d        = HOLD;
          swap_pending_d = 1'b1;
          wr_ready_d     = 1'b0;
        end
      end
      HOLD: begin
        if (frame_start) begin
          state_d        = FILL;
          active_bank_d  = ~active_bank_q;
          swap_pending_d = 1'b0;
          wr_ready_d     = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      active_bank_q  <= active_bank_d;
      swap_pending_q <= swap_pending_d;
      wr_ready_q     <= wr_ready_d;
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_sel_d   = rd_sel_q;
    rd_seen_d  = rd_seen_q;
    if (rd_en) begin
      rd_sel_d  = active_bank_q;
      rd_seen_d = 1'b1;
    end
  end

  // rd_seen_q forces zero outputs until the first read after reset, since the
  // bank read registers themselves carry no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_sel_q   <= rd_sel_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  assign wr_fire    = wr_valid && (state_q == FILL) && !rst;
  assign wr_addr    = pix_addr(wr_x, wr_y);
  assign rd_addr_up = pix_addr(rd_col, {1'b0, rd_row});
  assign rd_addr_lo = pix_addr(rd_col, {1'b1, rd_row});

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      matrix_fb_bank u_bank (
        .clk      (clk),
        .we       (wr_fire && (active_bank_q != 1'(gi))),
        .waddr    (wr_addr),
        .wdata    (rgb_t'(wr_rgb)),
        .re       (rd_en && !rst && (active_bank_q == 1'(gi))),
        .raddr_up (rd_addr_up),
        .raddr_lo (rd_addr_lo),
        .rdata_up (bank_up[gi]),
        .rdata_lo (bank_lo[gi])
      );
    end
  endgenerate

  assign wr_ready     = wr_ready_q;
  assign swap_pending = swap_pending_q;
  assign active_bank  = active_bank_q;
  assign rd_valid     = rd_valid_q;
  assign rd_rgb0      = rd_seen_q ? bank_up[rd_sel_q] : '0;
  assign rd_rgb1      = rd_seen_q ? bank_lo[rd_sel_q] : '0;

endmodule
